// File: rtl/riscv_ctrl_pkg.sv
// Shared types and opcode constants for the RV64I multicycle controller.
// Used by multicycle_ctrl and alu_op_decode.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_t;

    typedef enum logic [2:0] {
        IT_I  = 3'b000,
        IT_S  = 3'b001,
        IT_SB = 3'b010,
        IT_UJ = 3'b011,
        IT_U  = 3'b100
    } instr_type_t;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MDR    = 2'd1,
        WB_PC     = 2'd2,
        WB_IMM    = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_TRAP   = 2'd2
    } pc_src_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic instr_type_t instr_type_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IT_S;
            OP_BRANCH: return IT_SB;
            OP_JAL:    return IT_UJ;
            OP_LUI:    return IT_U;
            default:   return IT_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// ALU operation decode from funct3/funct7_b5 for R- and I-type arithmetic.
// sub_en is low for I-type so that funct7_b5 cannot turn addi into a subtract.
module alu_op_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       sub_en,
    output alu_op_t    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (sub_en && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b100:  alu_op = ALU_XOR;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the RV64I multicycle core.
// Optional illegal-opcode trap enabled by defining MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | compute branch/jump target into ALUOut, dispatch on opcode
// EXEC_R   | rs1 op rs2 into ALUOut
// EXEC_I   | rs1 op imm into ALUOut
// WB_ALU   | write ALUOut to rd
// ADDR     | rs1 + imm effective address into ALUOut
// MEM_RD   | load from ALUOut address
// WB_MEM   | write MDR to rd
// MEM_WR   | store to ALUOut address
// BRANCH   | compare rs1/rs2, conditionally load PC from ALUOut
// JAL      | link PC into rd, jump to ALUOut
// LUI      | write extended immediate to rd
// HALT     | stopped until reset
// TRAP     | EPC <= old_pc, PC <= trap vector (optional)
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , parameter logic [63:0] TRAP_VECTOR = 64'h0000_0000_0000_0100
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mem_addr_sel,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       aluout_write,
    output logic [2:0] instr_type,
    output logic       epc_write,
    output logic       halted,
    output logic       bus_err
);

    localparam int unsigned CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          waiting, timeout;
    alu_op_t       alu_op_arith;

    alu_op_decode u_alu_op_decode (
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .sub_en    (state == S_EXEC_R),
        .alu_op    (alu_op_arith)
    );

    assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // Timeout fires in the MEM_WAIT_MAX-th cycle without mem_ready; a ready in that cycle still completes.
    assign timeout = (MEM_WAIT_MAX != 0) && waiting && !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        pc_write     = 1'b0;
        pc_src       = PC_ALU;
        ir_write     = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALUOUT;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        alu_op       = ALU_ADD;
        aluout_write = 1'b0;
        epc_write    = 1'b0;
        halted       = 1'b0;
        instr_type   = instr_type_of(opcode);

        case (state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                alu_src_a    = 2'd2;
                alu_src_b    = 2'd2;
                aluout_write = 1'b1;
                case (opcode)
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_next = S_ADDR;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
                    OP_SYSTEM:         state_next = S_HALT;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: begin
                alu_src_a    = 2'd1;
                alu_op       = alu_op_arith;
                aluout_write = 1'b1;
                state_next   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a    = 2'd1;
                alu_src_b    = 2'd2;
                alu_op       = alu_op_arith;
                aluout_write = 1'b1;
                state_next   = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a    = 2'd1;
                alu_src_b    = 2'd2;
                aluout_write = 1'b1;
                state_next   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_rd       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready)    state_next = S_WB_MEM;
                else if (timeout) state_next = S_HALT;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                wb_sel     = WB_MDR;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_wr       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready)    state_next = S_FETCH;
                else if (timeout) state_next = S_HALT;
            end
            S_BRANCH: begin
                alu_src_a  = 2'd1;
                alu_op     = ALU_SUB;
                pc_src     = PC_ALUOUT;
                pc_write   = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);
                state_next = S_FETCH;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                wb_sel     = WB_PC;
                pc_write   = 1'b1;
                pc_src     = PC_ALUOUT;
                state_next = S_FETCH;
            end
            S_LUI: begin
                reg_write  = 1'b1;
                wb_sel     = WB_IMM;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                epc_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = PC_TRAP;
                state_next = S_FETCH;
            end
`endif
            default: state_next = S_FETCH;
        endcase

        // Hold the datapath idle while reset is asserted, whatever state the register still shows.
        if (reset) begin
            pc_write     = 1'b0;
            pc_src       = PC_ALU;
            ir_write     = 1'b0;
            mem_rd       = 1'b0;
            mem_wr       = 1'b0;
            mem_addr_sel = 1'b0;
            reg_write    = 1'b0;
            wb_sel       = WB_ALUOUT;
            alu_src_a    = 2'd0;
            alu_src_b    = 2'd0;
            alu_op       = ALU_ADD;
            aluout_write = 1'b0;
            epc_write    = 1'b0;
            halted       = 1'b0;
            instr_type   = IT_I;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl with MEM_WAIT_MAX = 4.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN for both bench and RTL to exercise the trap path.
module tb_multicycle_ctrl;

    logic       clock = 1'b0;
    logic       reset, funct7_b5, alu_zero, mem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       pc_write, ir_write, mem_rd, mem_wr, mem_addr_sel, reg_write;
    logic       aluout_write, epc_write, halted, bus_err;
    logic [1:0] pc_src, wb_sel, alu_src_a, alu_src_b;
    logic [2:0] alu_op, instr_type;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt;

    multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_b5    (funct7_b5),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ir_write     (ir_write),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr_sel (mem_addr_sel),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .aluout_write (aluout_write),
        .instr_type   (instr_type),
        .epc_write    (epc_write),
        .halted       (halted),
        .bus_err      (bus_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode    = op;
        funct3    = f3;
        funct7_b5 = f7;
    endtask

    // Fetch with n_wait stalled cycles; leaves the FSM in DECODE.
    task automatic do_fetch(input int n_wait, output int n_rd);
        n_rd = 0;
        for (int i = 0; i < n_wait; i++) begin
            mem_ready = 1'b0;
            #1;
            if (mem_rd) n_rd++;
            chk("fetch_wait_ir_write", ir_write, 0);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        if (mem_rd) n_rd++;
        chk("fetch_ir_write", ir_write, 1);
        chk("fetch_pc_write", pc_write, 1);
        chk("fetch_alu_src_b", alu_src_b, 1);
        cyc();
        mem_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; alu_zero = 1'b0; mem_ready = 1'b1;
        set_ir(7'b0000000, 3'b000, 1'b0);
        repeat (2) cyc();
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_alu_src_b", alu_src_b, 0);
        chk("rst_halted", halted, 0);
        chk("rst_bus_err", bus_err, 0);
        reset = 1'b0; mem_ready = 1'b0;

        // add x3,x1,x2
        set_ir(7'b0110011, 3'b000, 1'b0);
        do_fetch(0, rd_cnt);
        #1;
        chk("add_dec_aluout_write", aluout_write, 1);
        chk("add_dec_alu_src_a", alu_src_a, 2);
        chk("add_dec_alu_src_b", alu_src_b, 2);
        chk("add_dec_instr_type", instr_type, 0);
        cyc(); #1;
        chk("add_ex_alu_op", alu_op, 0);
        chk("add_ex_alu_src_a", alu_src_a, 1);
        chk("add_ex_alu_src_b", alu_src_b, 0);
        chk("add_ex_reg_write", reg_write, 0);
        cyc(); #1;
        chk("add_wb_reg_write", reg_write, 1);
        chk("add_wb_sel", wb_sel, 0);
        cyc(); #1;
        chk("add_back_fetch", mem_rd, 1);

        // sub, then xori/addi with funct7_b5 set
        set_ir(7'b0110011, 3'b000, 1'b1);
        do_fetch(0, rd_cnt);
        cyc(); #1;
        chk("sub_alu_op", alu_op, 1);
        cyc(); cyc();
        set_ir(7'b0010011, 3'b100, 1'b1);
        do_fetch(0, rd_cnt);
        cyc(); #1;
        chk("xori_alu_op", alu_op, 4);
        chk("xori_alu_src_b", alu_src_b, 2);
        cyc(); cyc();
        set_ir(7'b0010011, 3'b000, 1'b1);
        do_fetch(0, rd_cnt);
        cyc(); #1;
        chk("addi_no_sub", alu_op, 0);
        cyc(); cyc();

        // ld with three stall cycles in fetch and in memory read
        set_ir(7'b0000011, 3'b011, 1'b0);
        do_fetch(3, rd_cnt);
        chk("ld_fetch_rd_cycles", rd_cnt[7:0], 4);
        #1;
        chk("ld_dec_instr_type", instr_type, 0);
        cyc(); #1;
        chk("ld_addr_alu_src_a", alu_src_a, 1);
        chk("ld_addr_alu_src_b", alu_src_b, 2);
        chk("ld_addr_aluout_write", aluout_write, 1);
        cyc();
        rd_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mem_rd) rd_cnt++;
            chk("ld_mem_addr_sel", mem_addr_sel, 1);
            chk("ld_mem_reg_write", reg_write, 0);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        if (mem_rd) rd_cnt++;
        cyc();
        mem_ready = 1'b0;
        chk("ld_mem_rd_cycles", rd_cnt[7:0], 4);
        #1;
        chk("ld_wb_reg_write", reg_write, 1);
        chk("ld_wb_sel", wb_sel, 1);
        chk("ld_no_bus_err", bus_err, 0);
        cyc(); #1;
        chk("ld_wb_once", reg_write, 0);

        // beq / bne / other funct3 in BRANCH
        set_ir(7'b1100011, 3'b000, 1'b0);
        alu_zero = 1'b1;
        do_fetch(0, rd_cnt);
        #1;
        chk("beq_dec_instr_type", instr_type, 2);
        cyc(); #1;
        chk("beq_pc_write", pc_write, 1);
        chk("beq_pc_src", pc_src, 1);
        chk("beq_alu_op", alu_op, 1);
        cyc();
        set_ir(7'b1100011, 3'b001, 1'b0);
        do_fetch(0, rd_cnt);
        #1;
        chk("bne_dec_instr_type", instr_type, 2);
        cyc(); #1;
        chk("bne_z1_pc_write", pc_write, 0);
        alu_zero = 1'b0; #1;
        chk("bne_z0_pc_write", pc_write, 1);
        funct3 = 3'b100; #1;
        chk("blt_z0_pc_write", pc_write, 0);
        alu_zero = 1'b1; #1;
        chk("blt_z1_pc_write", pc_write, 0);
        cyc();
        alu_zero = 1'b0;

        // jal x1, 8 (0x008000EF)
        set_ir(7'b1101111, 3'b000, 1'b0);
        do_fetch(0, rd_cnt);
        #1;
        chk("jal_dec_instr_type", instr_type, 3);
        cyc(); #1;
        chk("jal_reg_write", reg_write, 1);
        chk("jal_wb_sel", wb_sel, 2);
        chk("jal_pc_write", pc_write, 1);
        chk("jal_pc_src", pc_src, 1);
        cyc(); #1;
        chk("jal_back_fetch", mem_rd, 1);
        chk("jal_fetch_reg_write", reg_write, 0);

        // lui
        set_ir(7'b0110111, 3'b000, 1'b0);
        do_fetch(0, rd_cnt);
        #1;
        chk("lui_dec_instr_type", instr_type, 4);
        cyc(); #1;
        chk("lui_reg_write", reg_write, 1);
        chk("lui_wb_sel", wb_sel, 3);
        cyc();

        // unknown opcode 0x7F
        set_ir(7'b1111111, 3'b000, 1'b0);
        do_fetch(0, rd_cnt);
        cyc(); #1;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        chk("trap_epc_write", epc_write, 1);
        chk("trap_pc_write", pc_write, 1);
        chk("trap_pc_src", pc_src, 2);
        cyc(); #1;
        chk("trap_back_fetch", mem_rd, 1);
`else
        chk("nop_back_fetch", mem_rd, 1);
        chk("nop_pc_write", pc_write, 0);
        chk("nop_epc_write", epc_write, 0);
        chk("nop_reg_write", reg_write, 0);
`endif

        // sd, reset in the middle of the memory write
        set_ir(7'b0100011, 3'b011, 1'b0);
        do_fetch(0, rd_cnt);
        #1;
        chk("sd_dec_instr_type", instr_type, 1);
        cyc(); cyc(); #1;
        chk("sd_mem_wr", mem_wr, 1);
        chk("sd_mem_addr_sel", mem_addr_sel, 1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; #1;
        chk("sd_reset_mem_wr", mem_wr, 0);
        chk("sd_reset_fetch", mem_rd, 1);

        // ecall halts until reset
        set_ir(7'b1110011, 3'b000, 1'b0);
        do_fetch(0, rd_cnt);
        cyc();
        mem_ready = 1'b1; #1;
        chk("halt_halted", halted, 1);
        chk("halt_mem_rd", mem_rd, 0);
        chk("halt_ir_write", ir_write, 0);
        repeat (3) cyc();
        #1;
        chk("halt_sticky", halted, 1);
        mem_ready = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0; #1;
        chk("halt_reset_halted", halted, 0);

        // fetch timeout: four stalled cycles then HALT with bus_err
        for (int i = 0; i < 4; i++) begin
            chk("to_pre_halted", halted, 0);
            chk("to_pre_bus_err", bus_err, 0);
            cyc(); #1;
        end
        chk("to_halted", halted, 1);
        chk("to_bus_err", bus_err, 1);
        chk("to_mem_rd", mem_rd, 0);
        reset = 1'b1; #1;
        chk("to_rst_halted", halted, 0);
        chk("to_rst_mem_rd", mem_rd, 0);
        cyc();
        reset = 1'b0; #1;
        chk("to_after_bus_err", bus_err, 0);
        chk("to_after_halted", halted, 0);
        chk("to_after_fetch", mem_rd, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle main control FSM for the RV64I core.
- Sequences fetch, decode, execute, memory and writeback over the shared PC/IR/ALU/ALUOut/MDR datapath.
- Drives `instr_type` into the immediate sign-extender, plus every mux select and write enable in the datapath.
- Handshakes with the single shared instruction/data memory port using `mem_ready`.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles to wait for `mem_ready` before a bus error; 0 = wait forever.
- TRAP_VECTOR, 64'h0000_0000_0000_0100: PC loaded on an illegal instruction (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0], valid from DECODE onward
- funct3  in  3  IR[14:12]
- funct7_b5  in  1  IR[30]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=TRAP_VECTOR
- ir_write  out  1  IR load enable
- mem_rd / mem_wr  out  1/1  memory read / write request
- mem_addr_sel  out  1  0=PC, 1=ALUOut
- reg_write  out  1  register file write enable
- wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC (link), 3=extended immediate
- alu_src_a  out  2  0=PC, 1=rs1, 2=old_pc
- alu_src_b  out  2  0=rs2, 1=const 4, 2=extended immediate
- alu_op  out  3  0=add, 1=sub, 2=and, 3=or, 4=xor, 5=slt
- aluout_write  out  1  ALUOut load enable
- instr_type  out  3  to the extender: 000 I, 001 S, 010 SB, 011 UJ, 100 U
- epc_write  out  1  EPC load (optional feature only)
- halted  out  1  core stopped
- bus_err  out  1  sticky memory timeout

Behaviour:
- Reset:
  - State goes to FETCH.
  - All enables and requests are 0; all selects are 0; `halted`=0, `bus_err`=0; wait counter is 0.
  - A `reset` asserted in any state aborts that state next edge, including during a memory wait.
- Output style:
  - All outputs are Moore (decoded from state), except `pc_write` in BRANCH and the `mem_ready`-qualified enables listed below.
- instr_type decoding (combinational from `opcode`, valid in every state):
  - load / I-arith / other → 000
  - store → 001
  - branch → 010
  - jal → 011
  - lui → 100
- FETCH:
  - Drives `mem_rd`=1, `mem_addr_sel`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=add.
  - On `mem_ready`: `ir_write`=1 and `pc_write`=1 (PC+4), then go to DECODE.
  - Otherwise remain in FETCH.
- DECODE:
  - `alu_src_a`=2, `alu_src_b`=2, `aluout_write`=1 (branch/jump target).
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0110111 → LUI
    - 1110011 → HALT
    - any other opcode → FETCH (NOP)
- EXEC_R:
  - `alu_op` from `funct3`/`funct7_b5`: add/sub/and/or/xor/slt.
  - `alu_src_a`=1, `alu_src_b`=0, `aluout_write`=1, then go to WB_ALU.
- EXEC_I:
  - As EXEC_R, but `alu_src_b`=2 and `funct7_b5` is ignored (no subi).
- WB_ALU: `reg_write`=1, `wb_sel`=0, then go to FETCH.
- ADDR:
  - add with rs1 + imm, `aluout_write`=1.
  - Loads go to MEM_RD; stores go to MEM_WR.
- MEM_RD:
  - `mem_rd`=1, `mem_addr_sel`=1.
  - On `mem_ready` go to WB_MEM; otherwise remain.
- WB_MEM: `reg_write`=1, `wb_sel`=1, then go to FETCH.
- MEM_WR:
  - `mem_wr`=1, `mem_addr_sel`=1.
  - On `mem_ready` go to FETCH; otherwise remain.
- BRANCH:
  - sub with rs1 − rs2.
  - `pc_write` = (`funct3`==000 & `alu_zero`) | (`funct3`==001 & !`alu_zero`); `pc_src`=1.
  - Any other `funct3` never writes the PC.
  - Go to FETCH.
- JAL:
  - `reg_write`=1, `wb_sel`=2 (the already incremented PC).
  - `pc_write`=1, `pc_src`=1.
  - Go to FETCH.
- LUI: `reg_write`=1, `wb_sel`=3, then go to FETCH.
- HALT:
  - `halted`=1; all enables and requests are 0.
  - Left only by `reset`.
- Wait counter:
  - Counts cycles in FETCH, MEM_RD and MEM_WR while `mem_ready`=0; clears on any state change.
  - If MEM_WAIT_MAX≠0 and the count reaches MEM_WAIT_MAX, set `bus_err`=1 and go to HALT.
  - `mem_ready` in the same cycle as the limit wins: the access completes.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP: `epc_write`=1 (captures old_pc), `pc_write`=1, `pc_src`=2, then go to FETCH.
- Undefined:
  - An unknown opcode is a NOP and goes to FETCH.
  - `epc_write` is tied to 0 and `pc_src`=2 is never driven.

Decomposition:
- Package `riscv_ctrl_pkg`:
  - Enums: state_t, alu_op_t, instr_type_t (with the extender's encodings), wb_sel_t, pc_src_t.
  - Opcode constants.
- One sub-module, `alu_op_decode`: combinational `funct3`/`funct7_b5` → alu_op_t.

Test Plan:
- add x3,x1,x2 (0x002081B3), `mem_ready` high every fetch → FETCH, DECODE, EXEC_R, WB_ALU; `reg_write`=1 in cycle 4, `alu_op`=add.
- ld with `mem_ready` delayed 3 cycles in both FETCH and MEM_RD → `mem_rd` held 4 cycles each; `reg_write` with `wb_sel`=1 exactly once.
- beq with `alu_zero`=1, then bne with `alu_zero`=1 → `pc_write`=1 with `pc_src`=1 only for beq; `instr_type`=010 in DECODE for both.
- jal (0x008000EF) → `instr_type`=011 in DECODE; JAL state asserts `reg_write`, `wb_sel`=2, `pc_write`; back in FETCH next cycle.
- MEM_WAIT_MAX=4, `mem_ready` held low in FETCH → `bus_err`=1 and `halted`=1 after 4 cycles; `reset` pulse returns to FETCH with all outputs 0.
- opcode 0x7F: with macro → TRAP, `pc_src`=2, `epc_write`=1; without macro → FETCH, no writes. `reset` asserted mid-MEM_WR → `mem_wr`=0 next cycle.
